square_fixed_n: RTL and testbench
=================================

// Module: square_fixed_n
// PURPOSE
//  Iterative fixed-point squarer: x = y*y for unsigned y = yint.ydec; inverse of the sqrt/Newton path.
//  Consumes the root produced by the sqrt datapath and rebuilds the radicand, for round-trip checks.
//  Also serves as a stand-alone squaring unit.
//  Shift-add, one multiplier bit per clock; start/busy/done handshake; result held until next start.
// PARAMETERS
//  INT_W   17   integer bits of y (root of a 33-bit sum of squares)
//  FRAC_W  16   fraction bits of y; also fraction bits of x output
// PORTS
//  clk_i    in   1           clock, all state on rising edge
//  rst_i    in   1           synchronous reset, active-high
//  start_i  in   1           request; sampled only in IDLE
//  yint_i   in   INT_W       integer part of y
//  ydec_i   in   FRAC_W      fraction part of y (weight 2^-FRAC_W per LSB)
//  busy_o   out  1           high in RUN and DONE
//  done_o   out  1           one-cycle pulse, result valid
//  xint_o   out  2*INT_W     integer part of y*y
//  xdec_o   out  FRAC_W      fraction part of y*y (truncated or rounded, see CONFIGURATION)
// BEHAVIOUR
//  Clock/reset: one clock clk_i; rst_i synchronous, active-high.
//  Reset: state IDLE; busy_o=0, done_o=0, xint_o=0, xdec_o=0, counter=0, accumulator=0.
//  W = INT_W+FRAC_W; operand a = {yint_i,ydec_i} is captured at the start edge; product P is 2*W bits.
//  IDLE: start_i=1 at edge k -> capture a into multiplicand and multiplier regs; clear acc; count=W-1; go RUN.
//  RUN: each cycle, if the multiplier LSB is 1 then acc += multiplicand << (W-1-count).
//    Alternatively, use an equivalent right-shift scheme. Shift the multiplier right.
//    When count==0 go DONE, else count-1. RUN lasts exactly W cycles.
//  DONE (1 cycle): register xint_o = P[2W-1:2*FRAC_W] and xdec_o = P[2*FRAC_W-1:FRAC_W] (+rounding).
//    done_o=1 -> IDLE.
//  Latency: done_o high exactly W+1 cycles after the start edge (34 at defaults). Throughput: one op per W+2 cycles.
//  start_i while busy_o=1 is ignored; it is not queued. Inputs are don't-care after the start edge.
//  Outputs hold the last result until the next DONE; they are not cleared on start.
//  Widths: no overflow is possible; the full product fits in 2W bits.
//  Rounding carry cannot overflow xint_o, because (2^INT_W-2^-FRAC_W)^2 + half LSB < 2^(2*INT_W).
//  Reset mid-operation: the next cycle is IDLE and all outputs are 0. No done_o is produced for the aborted op.
//  start_i and rst_i together: reset wins.
// CONFIGURATION
//  Macro SQUARE_ROUND_EN:
//   defined   -> round half-up at bit FRAC_W: add P[FRAC_W-1] into {xint,xdec}, with carry into xint_o.
//   undefined -> truncate; P[FRAC_W-1:0] is discarded.
//  Latency is identical in both builds; the rounding add is done in the DONE cycle.
// STRUCTURE
//  Package sqrt_pkg:
//    - INT_W/FRAC_W defaults
//    - typedef enum logic[1:0] {IDLE,RUN,DONE} sq_state_t
//    - typedef for the W-bit operand and the 2W-bit product
//  Sub-module shift_add_step_n: combinational single-bit accumulate step (acc, mcand, bit -> acc_next).
//  The top level holds the FSM, the counter and the output registers.
// TESTING (defaults INT_W=17, FRAC_W=16)
//  y=5.0 (yint=5, ydec=0), pulse start_i -> done_o at +34 cycles; xint_o=25, xdec_o=0; busy_o high 34 cycles.
//  y=1.5 (yint=1, ydec=0x8000) -> xint_o=2, xdec_o=0x4000. y=0 -> xint_o=0, xdec_o=0.
//  y=0x1FFFF.FFFF -> xint_o=0x3_FFFF_FFFC, xdec_o=0x0000 in both builds.
//  y=0.00B6 (ydec=0x00B6) -> xdec_o=0 truncated, 1 with SQUARE_ROUND_EN.
//    ydec=0x00B5 -> xdec_o=0 in both builds.
//  Start pulses at +5 and +20 during an op -> exactly one done_o at +34; the result is for the first operand.
//  Back-to-back: restart the cycle after done_o -> second done_o 35 cycles later.
//  rst_i at cycle 10 of RUN -> next cycle busy_o=0, outputs 0, no done_o.
//    A fresh start afterwards completes normally.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared definitions for the sqrt / square fixed-point datapaths.
package sqrt_pkg;
  localparam int INT_W_DEF  = 17;
  localparam int FRAC_W_DEF = 16;
  localparam int W_DEF      = INT_W_DEF + FRAC_W_DEF;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sq_state_t;

  typedef logic [W_DEF-1:0]   sq_opnd_t;
  typedef logic [2*W_DEF-1:0] sq_prod_t;
endpackage

// File: rtl/shift_add_step_n.sv
// One shift-add multiply step: conditionally add the multiplicand into the accumulator.
module shift_add_step_n #(
  parameter int PW = 66
) (
  input  logic [PW-1:0] acc_i,
  input  logic [PW-1:0] mcand_i,
  input  logic          bit_i,
  output logic [PW-1:0] acc_o
);
  assign acc_o = bit_i ? (acc_i + mcand_i) : acc_i;
endmodule

// File: rtl/square_fixed_n.sv
// Iterative unsigned fixed-point squarer x = y*y, one multiplier bit per clock.
// Build option: define SQUARE_ROUND_EN for round-half-up of xdec_o, otherwise truncate.
module square_fixed_n
  import sqrt_pkg::*;
#(
  parameter int INT_W  = INT_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [INT_W-1:0]     yint_i,
  input  logic [FRAC_W-1:0]    ydec_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*INT_W-1:0]   xint_o,
  output logic [FRAC_W-1:0]    xdec_o
);
  localparam int W  = INT_W + FRAC_W;
  localparam int PW = 2 * W;
  localparam int CW = $clog2(W);
  localparam int XW = 2 * INT_W + FRAC_W;

  sq_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        mcand_q, mcand_d;
  logic [W-1:0]         mplier_q, mplier_d;
  logic [PW-1:0]        acc_q, acc_d;
  logic [2*INT_W-1:0]   xint_q, xint_d;
  logic [FRAC_W-1:0]    xdec_q, xdec_d;
  logic                 done_q, done_d;

  logic [PW-1:0]        acc_step;
  logic [XW-1:0]        x_trunc, x_fin;
  logic                 unused_lo;

  shift_add_step_n #(.PW(PW)) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .bit_i   (mplier_q[0]),
    .acc_o   (acc_step)
  );

  // Bits below the output LSB only ever feed the rounding decision.
  assign x_trunc   = acc_q[PW-1:FRAC_W];
  assign unused_lo = ^acc_q[FRAC_W-1:0];
`ifdef SQUARE_ROUND_EN
  assign x_fin = x_trunc + {{(XW-1){1'b0}}, acc_q[FRAC_W-1]};
`else
  assign x_fin = x_trunc;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    xint_d   = xint_q;
    xdec_d   = xdec_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          mcand_d  = {{W{1'b0}}, yint_i, ydec_i};
          mplier_d = {yint_i, ydec_i};
          acc_d    = '0;
          cnt_d    = CW'(W - 1);
          state_d  = RUN;
        end
      end
      RUN: begin
        // Multiplicand walks left while the multiplier walks right.
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        xint_d  = x_fin[XW-1:FRAC_W];
        xdec_d  = x_fin[FRAC_W-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      xint_q   <= '0;
      xdec_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      xint_q   <= xint_d;
      xdec_q   <= xdec_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign xint_o = xint_q;
  assign xdec_o = xdec_q;
endmodule

// File: tb/tb_square_fixed_n.sv
// Directed bench for square_fixed_n with a cycle-level model of the squarer's timing.
module tb_square_fixed_n;
  localparam int INT_W  = 17;
  localparam int FRAC_W = 16;
  localparam int W      = INT_W + FRAC_W;
  localparam int XW     = 2 * INT_W + FRAC_W;

  logic                clk = 1'b0;
  logic                rst, start;
  logic [INT_W-1:0]    yint;
  logic [FRAC_W-1:0]   ydec;
  logic                busy, done;
  logic [2*INT_W-1:0]  xint;
  logic [FRAC_W-1:0]   xdec;

  square_fixed_n #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .yint_i  (yint),
    .ydec_i  (ydec),
    .busy_o  (busy),
    .done_o  (done),
    .xint_o  (xint),
    .xdec_o  (xdec)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, cyc = 0;
  bit chk_en = 1'b0;

  // Model: an accepted op at edge s is busy through edge s+W, result appears at edge s+W+1.
  bit              m_act = 1'b0, m_done = 1'b0;
  int              m_s = 0;
  logic [W-1:0]    m_a = '0;
  logic [XW-1:0]   m_x = '0;

  function automatic logic [XW-1:0] sq_model(input logic [W-1:0] a);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, a};
`ifdef SQUARE_ROUND_EN
    return p[2*W-1:FRAC_W] + XW'(p[FRAC_W-1]);
`else
    return p[2*W-1:FRAC_W];
`endif
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_act  <= 1'b0;
      m_done <= 1'b0;
      m_x    <= '0;
    end else begin
      m_done <= m_act && (cyc + 1 == m_s + W + 1);
      if (m_act && (cyc + 1 == m_s + W + 1)) begin
        m_act <= 1'b0;
        m_x   <= sq_model(m_a);
      end
      if (start && (!m_act || (cyc + 1 == m_s + W + 1))) begin
        m_act <= 1'b1;
        m_s   <= cyc + 1;
        m_a   <= {yint, ydec};
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_act));
      chk("done", 64'(done), 64'(m_done));
      chk("xint", 64'(xint), 64'(m_x[XW-1:FRAC_W]));
      chk("xdec", 64'(xdec), 64'(m_x[FRAC_W-1:0]));
    end
  end

  // Called just after a negedge; returns latency from the start edge and busy cycles.
  task automatic run_op(input logic [INT_W-1:0] yi, input logic [FRAC_W-1:0] yd,
                        input bit extra, output int lat, output int bcnt);
    int t0;
    t0    = cyc;
    start = 1'b1;
    yint  = yi;
    ydec  = yd;
    lat   = -1;
    bcnt  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = extra && (i == 5 || i == 20);
      yint  = INT_W'($urandom);
      ydec  = FRAC_W'($urandom);
      if (done) begin
        lat = cyc - (t0 + 1);
        break;
      end
      if (busy) bcnt++;
    end
    if (lat < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: no done_o within 40 cycles for y=%0h.%0h", yi, yd);
    end
  endtask

  int lat, bc, d1, d2, ndone;

  initial begin
    rst = 1'b1; start = 1'b0; yint = '0; ydec = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_xint", 64'(xint), 64'd0);
    chk("rst_xdec", 64'(xdec), 64'd0);
    rst = 1'b0;

    run_op(17'd5, 16'h0000, 1'b0, lat, bc);
    chk("y5_lat",  64'(lat), 64'd34);
    chk("y5_busy", 64'(bc),  64'd34);
    chk("y5_xint", 64'(xint), 64'd25);
    chk("y5_xdec", 64'(xdec), 64'd0);

    run_op(17'd1, 16'h8000, 1'b0, lat, bc);
    chk("y1p5_lat",  64'(lat), 64'd34);
    chk("y1p5_xint", 64'(xint), 64'd2);
    chk("y1p5_xdec", 64'(xdec), 64'h4000);

    run_op(17'd0, 16'h0000, 1'b0, lat, bc);
    chk("y0_xint", 64'(xint), 64'd0);
    chk("y0_xdec", 64'(xdec), 64'd0);

    run_op(17'h1FFFF, 16'hFFFF, 1'b0, lat, bc);
    chk("ymax_xint", 64'(xint), 64'h3_FFFF_FFFC);
    chk("ymax_xdec", 64'(xdec), 64'h0);

    run_op(17'd0, 16'h00B6, 1'b0, lat, bc);
    chk("yB6_xint", 64'(xint), 64'd0);
`ifdef SQUARE_ROUND_EN
    chk("yB6_xdec", 64'(xdec), 64'd1);
`else
    chk("yB6_xdec", 64'(xdec), 64'd0);
`endif

    run_op(17'd0, 16'h00B5, 1'b0, lat, bc);
    chk("yB5_xdec", 64'(xdec), 64'd0);

    run_op(17'd3, 16'h0000, 1'b1, lat, bc);
    chk("ign_lat",  64'(lat), 64'd34);
    chk("ign_xint", 64'(xint), 64'd9);

    run_op(17'd2, 16'h0000, 1'b0, lat, bc);
    d1 = cyc;
    run_op(17'd7, 16'h0000, 1'b0, lat, bc);
    d2 = cyc;
    chk("b2b_gap",  64'(d2 - d1), 64'd35);
    chk("b2b_xint", 64'(xint), 64'd49);

    // Abort in the middle of RUN.
    start = 1'b1; yint = 17'd9; ydec = 16'h0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_xint", 64'(xint), 64'd0);
    chk("abort_xdec", 64'(xdec), 64'd0);
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_nodone", 64'(ndone), 64'd0);

    run_op(17'd4, 16'h4000, 1'b0, lat, bc);
    chk("post_lat",  64'(lat), 64'd34);
    chk("post_xint", 64'(xint), 64'd18);
    chk("post_xdec", 64'(xdec), 64'h1000);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
